// File: rtl/voice_allocator_pkg.sv
// Shared MIDI synth types: field widths, allocator FSM encoding, slot-table commands.
// Pure declarations; no latency, no backpressure.
package midi_synth_pkg;

    localparam int MIDI_NOTE_W        = 7;
    localparam int MIDI_VEL_W         = 7;
    localparam int TUNING_W           = 32;
    localparam int VOICE_IDX_W        = 8;
    localparam int ACTIVE_W           = 9;
    localparam int DEFAULT_NUM_VOICES = 16;
    localparam int DEFAULT_AGE_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2
    } alloc_state_t;

    typedef enum logic [1:0] {
        TBL_NONE  = 2'd0,
        TBL_ALLOC = 2'd1,
        TBL_FREE  = 2'd2
    } tbl_cmd_t;

    // note_on here is the effective direction: a zero-velocity note-on is stored as 0.
    typedef struct packed {
        logic                   note_on;
        logic [MIDI_NOTE_W-1:0] note;
        logic [MIDI_VEL_W-1:0]  velocity;
        logic [TUNING_W-1:0]    tuning;
    } midi_event_t;

endpackage

// File: rtl/voice_allocator_if.sv
// MIDI event input handshake plus voice command output bundle of the allocator.
// slave = allocator side, master = event source / command consumer side.
interface voice_allocator_if;
    import midi_synth_pkg::*;

    logic                   i_event_valid;
    logic                   o_event_ready;
    logic                   i_event_note_on;
    logic [MIDI_NOTE_W-1:0] i_event_note;
    logic [MIDI_VEL_W-1:0]  i_event_velocity;
    logic [TUNING_W-1:0]    i_event_tuning_code;
    logic                   o_note_status;
    logic [VOICE_IDX_W-1:0] o_voice_index;
    logic [TUNING_W-1:0]    o_tuning_code;
    logic [MIDI_VEL_W-1:0]  o_velocity;
    logic                   o_flag;
    logic [ACTIVE_W-1:0]    o_active_voices;

    modport slave (
        input  i_event_valid, i_event_note_on, i_event_note, i_event_velocity, i_event_tuning_code,
        output o_event_ready, o_note_status, o_voice_index, o_tuning_code, o_velocity, o_flag,
               o_active_voices
    );

    modport master (
        output i_event_valid, i_event_note_on, i_event_note, i_event_velocity, i_event_tuning_code,
        input  o_event_ready, o_note_status, o_voice_index, o_tuning_code, o_velocity, o_flag,
               o_active_voices
    );

endinterface

// File: rtl/voice_allocator_slot_table.sv
// Per-voice held/note/age store: combinational read by index, one registered update per cycle.
// Updates land on the next edge; always accepts commands (no backpressure).
module voice_slot_table
    import midi_synth_pkg::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int AGE_W      = DEFAULT_AGE_W,
    parameter int IDX_W      = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic                   rd_held,
    output logic [MIDI_NOTE_W-1:0] rd_note,
    output logic [AGE_W-1:0]       rd_age,
    input  tbl_cmd_t               wr_cmd,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [MIDI_NOTE_W-1:0] wr_note
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [NUM_VOICES-1:0]  held_q;
    logic [MIDI_NOTE_W-1:0] note_q [NUM_VOICES];
    logic [AGE_W-1:0]       age_q  [NUM_VOICES];

    assign rd_held = held_q[rd_idx];
    assign rd_note = note_q[rd_idx];
    assign rd_age  = age_q[rd_idx];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            held_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                case (wr_cmd)
                    TBL_ALLOC: begin
                        if (IDX_W'(i) == wr_idx) begin
                            held_q[i] <= 1'b1;
                            note_q[i] <= wr_note;
                            age_q[i]  <= '0;
                        end else if (held_q[i] && (age_q[i] != AGE_MAX)) begin
                            age_q[i] <= age_q[i] + 1'b1;
                        end
                    end
                    TBL_FREE: begin
                        if (IDX_W'(i) == wr_idx) begin
                            held_q[i] <= 1'b0;
                            age_q[i]  <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Maps MIDI note events onto voices: retrigger same note, else lowest free, else steal oldest.
// Command strobe NUM_VOICES+2 cycles after accept; ready held low from accept through the strobe cycle.
module voice_allocator
    import midi_synth_pkg::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int AGE_W      = DEFAULT_AGE_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    voice_allocator_if.slave bus
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_VOICES - 1);

    alloc_state_t state_q, state_d;
    logic [IDX_W-1:0] scan_q;
    midi_event_t      ev_q;

    logic             match_found_q, free_found_q, steal_found_q;
    logic [IDX_W-1:0] match_idx_q, free_idx_q, steal_idx_q;
    logic [AGE_W-1:0] steal_age_q;

    logic                   rd_held;
    logic [MIDI_NOTE_W-1:0] rd_note;
    logic [AGE_W-1:0]       rd_age;

    tbl_cmd_t         tbl_cmd;
    logic [IDX_W-1:0] tbl_idx;
    logic             issue_fire, cnt_inc, cnt_dec;
    logic             accept;

    logic                   flag_q, status_q;
    logic [IDX_W-1:0]       idx_q;
    logic [TUNING_W-1:0]    tuning_q;
    logic [MIDI_VEL_W-1:0]  vel_q;
    logic [ACTIVE_W-1:0]    active_q;

    voice_slot_table #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .IDX_W      (IDX_W)
    ) u_table (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .rd_idx  (scan_q),
        .rd_held (rd_held),
        .rd_note (rd_note),
        .rd_age  (rd_age),
        .wr_cmd  (tbl_cmd),
        .wr_idx  (tbl_idx),
        .wr_note (ev_q.note)
    );

    // The strobe cycle itself must not accept, so ready also waits for flag_q to clear.
    assign bus.o_event_ready   = !i_reset && (state_q == ST_IDLE) && !flag_q;
    assign accept              = bus.i_event_valid && bus.o_event_ready;
    assign bus.o_flag          = flag_q;
    assign bus.o_note_status   = status_q;
    assign bus.o_voice_index   = VOICE_IDX_W'(idx_q);
    assign bus.o_tuning_code   = tuning_q;
    assign bus.o_velocity      = vel_q;
    assign bus.o_active_voices = active_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tbl_cmd    = TBL_NONE;
        tbl_idx    = match_idx_q;
        issue_fire = 1'b0;
        cnt_inc    = 1'b0;
        cnt_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (scan_q == LAST_SLOT) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
                if (ev_q.note_on) begin
                    issue_fire = 1'b1;
                    tbl_cmd    = TBL_ALLOC;
                    if (match_found_q) begin
                        tbl_idx = match_idx_q;
                    end else if (free_found_q) begin
                        tbl_idx = free_idx_q;
                        cnt_inc = 1'b1;
                    end else begin
                        tbl_idx = steal_idx_q;
                    end
                end else if (match_found_q) begin
                    issue_fire = 1'b1;
                    tbl_cmd    = TBL_FREE;
                    tbl_idx    = match_idx_q;
                    cnt_dec    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            scan_q        <= '0;
            ev_q          <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            steal_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_idx_q    <= '0;
            steal_idx_q   <= '0;
            steal_age_q   <= '0;
        end else if (accept) begin
            scan_q           <= '0;
            ev_q.note_on     <= bus.i_event_note_on && (bus.i_event_velocity != '0);
            ev_q.note        <= bus.i_event_note;
            ev_q.velocity    <= bus.i_event_velocity;
            ev_q.tuning      <= bus.i_event_tuning_code;
            match_found_q    <= 1'b0;
            free_found_q     <= 1'b0;
            steal_found_q    <= 1'b0;
        end else if (state_q == ST_SCAN) begin
            scan_q <= scan_q + 1'b1;
            // Ascending scan: first hit is the lowest index; strict '>' keeps the lower index on age ties.
            if (rd_held && (rd_note == ev_q.note) && !match_found_q) begin
                match_found_q <= 1'b1;
                match_idx_q   <= scan_q;
            end
            if (!rd_held && !free_found_q) begin
                free_found_q <= 1'b1;
                free_idx_q   <= scan_q;
            end
            if (rd_held && (!steal_found_q || (rd_age > steal_age_q))) begin
                steal_found_q <= 1'b1;
                steal_idx_q   <= scan_q;
                steal_age_q   <= rd_age;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            flag_q   <= 1'b0;
            status_q <= 1'b0;
            idx_q    <= '0;
            tuning_q <= '0;
            vel_q    <= '0;
            active_q <= '0;
        end else begin
            flag_q <= issue_fire;
            if (issue_fire) begin
                status_q <= ev_q.note_on;
                idx_q    <= tbl_idx;
                tuning_q <= ev_q.tuning;
                vel_q    <= ev_q.velocity;
            end
            if (cnt_inc) begin
                active_q <= active_q + ACTIVE_W'(1);
            end else if (cnt_dec) begin
                active_q <= active_q - ACTIVE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed vector table for voice_allocator plus hand sequences for reset and mid-scan abort.
module tb_voice_allocator;
    import midi_synth_pkg::*;

    localparam int NV      = 16;
    localparam int CMD_LAT = NV + 2;

    typedef struct {
        logic        on;
        logic [6:0]  note;
        logic [6:0]  vel;
        logic [31:0] tune;
        logic        exp_flag;
        logic        exp_st;
        logic [7:0]  exp_idx;
        logic [8:0]  exp_act;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    voice_allocator_if bus ();

    voice_allocator #(
        .NUM_VOICES (NV),
        .AGE_W      (8)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic on, input int note, input int vel, input logic [31:0] tune,
                                input logic ef, input logic est, input int eidx, input int eact);
        vec_t v;
        v.on = on;         v.note = 7'(note);   v.vel = 7'(vel);    v.tune = tune;
        v.exp_flag = ef;   v.exp_st = est;      v.exp_idx = 8'(eidx); v.exp_act = 9'(eact);
        return v;
    endfunction

    // Presents an event and returns just after the accepting edge.
    task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel, input logic [31:0] tune);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.i_event_valid       = 1'b1;
        bus.i_event_note_on     = on;
        bus.i_event_note        = note;
        bus.i_event_velocity    = vel;
        bus.i_event_tuning_code = tune;
        while (!bus.o_event_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.o_event_ready) check("ready_timeout", 64'(bus.o_event_ready), 64'd1);
        @(posedge clk);
        #1 bus.i_event_valid = 1'b0;
    endtask

    task automatic wait_flag(input int budget, output int lat);
        lat = 0;
        for (int n = 1; n <= budget && lat == 0; n++) begin
            @(negedge clk);
            if (bus.o_flag) lat = n;
        end
    endtask

    initial begin
        int lat;
        bus.i_event_valid       = 1'b0;
        bus.i_event_note_on     = 1'b0;
        bus.i_event_note        = '0;
        bus.i_event_velocity    = '0;
        bus.i_event_tuning_code = '0;

        // Basic allocation, release, retrigger, unknown note-off, zero-velocity note-on.
        vecs.push_back(mk(1, 60, 100, 32'h0123_4567, 1, 1, 0, 1));
        vecs.push_back(mk(1, 62,  90, 32'h0000_0062, 1, 1, 1, 2));
        vecs.push_back(mk(1, 64,  80, 32'h0000_0064, 1, 1, 2, 3));
        vecs.push_back(mk(0, 62,  10, 32'hAAAA_0062, 1, 0, 1, 2));
        vecs.push_back(mk(1, 67,  70, 32'h0000_0067, 1, 1, 1, 3));
        vecs.push_back(mk(1, 60,  50, 32'h5555_0060, 1, 1, 0, 3));
        vecs.push_back(mk(0, 90,  20, 32'h0000_0090, 0, 0, 0, 3));
        vecs.push_back(mk(1, 60,   0, 32'h1111_0060, 1, 0, 0, 2));
        vecs.push_back(mk(0, 64,  40, 32'h2222_0064, 1, 0, 2, 1));
        vecs.push_back(mk(0, 67,  40, 32'h3333_0067, 1, 0, 1, 0));
        // Fill every voice, then steal oldest, retrigger, and prefer a freed slot over stealing.
        for (int i = 0; i < NV; i++) vecs.push_back(mk(1, 40 + i, 64, 32'h1000 + 32'(i), 1, 1, i, i + 1));
        vecs.push_back(mk(1, 70, 99, 32'hCAFE_0070, 1, 1, 0, 16));
        vecs.push_back(mk(1, 71, 98, 32'hCAFE_0071, 1, 1, 1, 16));
        vecs.push_back(mk(1, 45, 33, 32'hBEEF_0045, 1, 1, 5, 16));
        vecs.push_back(mk(0, 70, 12, 32'hDEAD_0070, 1, 0, 0, 15));
        vecs.push_back(mk(1, 72, 77, 32'hF00D_0072, 1, 1, 0, 16));

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_flag",   64'(bus.o_flag),          64'd0);
        check("rst_ready",  64'(bus.o_event_ready),   64'd0);
        check("rst_active", 64'(bus.o_active_voices), 64'd0);
        check("rst_status", 64'(bus.o_note_status),   64'd0);
        check("rst_index",  64'(bus.o_voice_index),   64'd0);
        check("rst_tuning", 64'(bus.o_tuning_code),   64'd0);
        check("rst_vel",    64'(bus.o_velocity),      64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.o_event_ready), 64'd1);

        foreach (vecs[k]) begin
            send(vecs[k].on, vecs[k].note, vecs[k].vel, vecs[k].tune);
            if (vecs[k].exp_flag) begin
                wait_flag(CMD_LAT + 10, lat);
                check($sformatf("v%0d_latency", k), 64'(lat), 64'(CMD_LAT));
                if (lat != 0) begin
                    check($sformatf("v%0d_status", k), 64'(bus.o_note_status), 64'(vecs[k].exp_st));
                    check($sformatf("v%0d_index", k),  64'(bus.o_voice_index), 64'(vecs[k].exp_idx));
                    check($sformatf("v%0d_vel", k),    64'(bus.o_velocity),    64'(vecs[k].vel));
                    check($sformatf("v%0d_tune", k),   64'(bus.o_tuning_code), 64'(vecs[k].tune));
                    check($sformatf("v%0d_ready_in_flag", k), 64'(bus.o_event_ready), 64'd0);
                    @(negedge clk);
                    check($sformatf("v%0d_flag_drop", k), 64'(bus.o_flag), 64'd0);
                end
            end else begin
                wait_flag(CMD_LAT, lat);
                check($sformatf("v%0d_no_flag", k), 64'(lat), 64'd0);
            end
            check($sformatf("v%0d_ready_after", k), 64'(bus.o_event_ready), 64'd1);
            check($sformatf("v%0d_active", k),      64'(bus.o_active_voices), 64'(vecs[k].exp_act));
        end

        // Reset during the scan: no command, table cleared, next note-on lands on voice 0.
        send(1'b1, 7'd80, 7'd60, 32'h0000_0080);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 64'(bus.o_event_ready), 64'd0);
        rst = 1'b0;
        wait_flag(CMD_LAT + 5, lat);
        check("midrst_no_flag", 64'(lat),                   64'd0);
        check("midrst_active",  64'(bus.o_active_voices),   64'd0);
        check("midrst_ready2",  64'(bus.o_event_ready),     64'd1);
        send(1'b1, 7'd81, 7'd61, 32'h0000_0081);
        wait_flag(CMD_LAT + 10, lat);
        check("midrst_next_lat",    64'(lat),                 64'(CMD_LAT));
        check("midrst_next_index",  64'(bus.o_voice_index),   64'd0);
        check("midrst_next_status", 64'(bus.o_note_status),   64'd1);
        @(negedge clk);
        check("midrst_next_active", 64'(bus.o_active_voices), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
